// File: rtl/fetch_ram_wr_pack.sv
// fetch_ram_wr_pack
//   Write stage in front of the fetch-stage reference RAM. 32-bit reference
//   pixel beats arrive over valid/ready. Each pair of beats is packed into one
//   64-bit word, with the first beat in the low half. The word is written to
//   the RAM write port at circularly incrementing addresses starting from a
//   programmed base. The block reports completion of the programmed burst.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   start_i      start-burst pulse, honoured only while idle
//   base_addr_i  first RAM address of the burst (sampled with start_i)
//   word_num_i   number of 64-bit words in the burst (sampled with start_i)
//   in_valid_i   input beat valid
//   in_data_i    input beat data
//   in_ready_o   block can accept a beat
//   wren_o       RAM write enable
//   wraddr_o     RAM write address (holds when wren_o is low)
//   wrdata_o     RAM write data (holds when wren_o is low)
//   busy_o       burst in progress
//   done_o       one-cycle pulse coincident with the final write
//   err_o        one-cycle pulse: start rejected (zero length or base out of range)
module fetch_ram_wr_pack #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 144
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] word_num_i,
    input  logic                  in_valid_i,
    input  logic [IN_WIDTH-1:0]   in_data_i,
    output logic                  in_ready_o,
    output logic                  wren_o,
    output logic [ADDR_WIDTH-1:0] wraddr_o,
    output logic [OUT_WIDTH-1:0]  wrdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    // One extra bit so a DEPTH equal to 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr;     // address of the next word to write
    logic [ADDR_WIDTH-1:0]   r_remain;   // words still to be written
    logic [IN_WIDTH-1:0]     r_low;
    logic                    r_wren;
    logic [ADDR_WIDTH-1:0]   r_wraddr;
    logic [OUT_WIDTH-1:0]    r_wrdata;
    logic                    r_done;
    logic                    r_err;

    logic                    w_start_ok;
    logic                    w_start_err;
    logic                    w_low_accept;
    logic                    w_write;
    logic                    w_last;
    logic [ADDR_WIDTH-1:0]   w_addr_inc;

    // Next-state and control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_ok   = 1'b0;
        w_start_err  = 1'b0;
        w_low_accept = 1'b0;
        w_write      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (word_num_i == '0 || {1'b0, base_addr_i} >= LP_DEPTH) begin
                        w_start_err = 1'b1;
                    end else begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (in_valid_i) begin
                    w_low_accept = 1'b1;
                    w_state_nxt  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (in_valid_i) begin
                    w_write = 1'b1;
                    if (r_remain == ADDR_WIDTH'(1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LOW;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Wrap at DEPTH rather than at the natural 2**ADDR_WIDTH boundary.
    assign w_addr_inc = (r_addr == LP_LAST) ? '0 : r_addr + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_low    <= '0;
            r_wren   <= 1'b0;
            r_wraddr <= '0;
            r_wrdata <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wren <= w_write;
            r_done <= w_last;
            r_err  <= w_start_err;
            if (w_start_ok) begin
                r_addr   <= base_addr_i;
                r_remain <= word_num_i;
            end
            if (w_low_accept) begin
                r_low <= in_data_i;
            end
            if (w_write) begin
                r_wraddr <= r_addr;
                r_wrdata <= {in_data_i, r_low};
                r_addr   <= w_addr_inc;
                r_remain <= r_remain - 1'b1;
            end
        end
    end

    assign in_ready_o = (r_state != ST_IDLE);
    assign busy_o     = (r_state != ST_IDLE);
    assign wren_o     = r_wren;
    assign wraddr_o   = r_wraddr;
    assign wrdata_o   = r_wrdata;
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule

// File: tb/tb_fetch_ram_wr_pack.sv
// Testbench for fetch_ram_wr_pack: table of bursts, hand-written corner
// sequences and randomized bursts, all checked against a word-level model.
module tb_fetch_ram_wr_pack;

    localparam int DEPTH = 144;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  base_addr_i;
    logic [7:0]  word_num_i;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        wren_o;
    logic [7:0]  wraddr_o;
    logic [63:0] wrdata_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int passes = 0;

    fetch_ram_wr_pack #(
        .IN_WIDTH  (32),
        .OUT_WIDTH (64),
        .ADDR_WIDTH(8),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .word_num_i (word_num_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .wren_o     (wren_o),
        .wraddr_o   (wraddr_o),
        .wrdata_o   (wrdata_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int base;
        int num;
        int vmode;     // 0: valid every cycle, 1: random bubbles, 2: 1,0,0 pattern
        bit exp_err;
        int exp_last;  // address of the final write
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue_start(input int base, input int num);
        start_i     = 1'b1;
        base_addr_i = base[7:0];
        word_num_i  = num[7:0];
        step();
        start_i = 1'b0;
    endtask

    task automatic err_start(input int base, input int num);
        issue_start(base, num);
        chk("err_pulse", err_o, 1);
        chk("err_busy", busy_o, 0);
        chk("err_wren", wren_o, 0);
        chk("err_done", done_o, 0);
        chk("err_ready", in_ready_o, 0);
        step();
        chk("err_clear", err_o, 0);
        chk("err_busy2", busy_o, 0);
        chk("err_wren2", wren_o, 0);
    endtask

    // Drives 2*num beats and checks each write against the model: word w goes
    // to (base+w) mod DEPTH one cycle after its high beat is accepted.
    task automatic feed_burst(input int base, input int num, input int vmode, input bit pat,
                              input bit chain, input int nbase, input int nnum,
                              output int last_addr);
        int          beats_left;
        int          idx;
        int          w;
        int          cyc;
        bit          pending;
        bit          v;
        logic [31:0] lo;
        logic [31:0] data;
        logic [63:0] exp_data;
        int          exp_addr;
        beats_left = 2 * num;
        idx        = 0;
        w          = 0;
        cyc        = 0;
        pending    = 1'b0;
        lo         = '0;
        exp_data   = '0;
        exp_addr   = 0;
        last_addr  = -1;
        while ((beats_left > 0 || pending) && cyc < 2000) begin
            chk("err_quiet", err_o, 0);
            if (pending) begin
                chk("wren", wren_o, 1);
                chk("wraddr", wraddr_o, exp_addr);
                chk("wrdata", wrdata_o, exp_data);
                chk("done", done_o, (w == num));
                chk("busy_at_write", busy_o, (w != num));
                last_addr = exp_addr;
                pending   = 1'b0;
            end else begin
                chk("no_wren", wren_o, 0);
                chk("no_done", done_o, 0);
            end
            if (beats_left > 0) begin
                chk("in_ready", in_ready_o, 1);
                chk("busy", busy_o, 1);
                case (vmode)
                    1:       v = ($urandom_range(0, 3) != 0);
                    2:       v = (cyc % 3 == 0);
                    default: v = 1'b1;
                endcase
                data = pat ? 32'((idx + 1) * 32'h11111111) : $urandom;
                in_valid_i = v;
                in_data_i  = data;
                // A stray zero-length start would raise err_o if not ignored.
                start_i     = (vmode == 1) && ($urandom_range(0, 7) == 0);
                base_addr_i = '0;
                word_num_i  = '0;
                if (v) begin
                    if (idx % 2 == 0) begin
                        lo = data;
                    end else begin
                        exp_data = {data, lo};
                        exp_addr = (base + w) % DEPTH;
                        w++;
                        pending = 1'b1;
                    end
                    idx++;
                    beats_left--;
                end
            end else begin
                in_valid_i = 1'b0;
                start_i    = 1'b0;
                if (chain) begin
                    start_i     = 1'b1;
                    base_addr_i = nbase[7:0];
                    word_num_i  = nnum[7:0];
                end
            end
            step();
            cyc++;
        end
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        if (cyc >= 2000) chk("timeout", 1, 0);
        if (!chain) begin
            chk("idle_busy", busy_o, 0);
            chk("idle_ready", in_ready_o, 0);
            chk("idle_wren", wren_o, 0);
            chk("idle_done", done_o, 0);
        end
    endtask

    initial begin
        int la;
        int rb;
        int rn;

        vecs[0] = '{base: 0,   num: 2,   vmode: 0, exp_err: 1'b0, exp_last: 1};
        vecs[1] = '{base: 142, num: 4,   vmode: 0, exp_err: 1'b0, exp_last: 1};
        vecs[2] = '{base: 0,   num: 1,   vmode: 2, exp_err: 1'b0, exp_last: 0};
        vecs[3] = '{base: 0,   num: 0,   vmode: 0, exp_err: 1'b1, exp_last: -1};
        vecs[4] = '{base: 144, num: 1,   vmode: 0, exp_err: 1'b1, exp_last: -1};
        vecs[5] = '{base: 143, num: 1,   vmode: 1, exp_err: 1'b0, exp_last: 143};
        vecs[6] = '{base: 100, num: 150, vmode: 1, exp_err: 1'b0, exp_last: 105};
        vecs[7] = '{base: 255, num: 3,   vmode: 0, exp_err: 1'b1, exp_last: -1};
        vecs[8] = '{base: 50,  num: 3,   vmode: 1, exp_err: 1'b0, exp_last: 52};

        rst_i       = 1'b1;
        start_i     = 1'b0;
        base_addr_i = '0;
        word_num_i  = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        repeat (3) step();
        chk("rst_ready", in_ready_o, 0);
        chk("rst_wren", wren_o, 0);
        chk("rst_wraddr", wraddr_o, 0);
        chk("rst_wrdata", wrdata_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 1'b0;
        step();

        // Table-driven bursts.
        foreach (vecs[i]) begin
            if (vecs[i].exp_err) begin
                err_start(vecs[i].base, vecs[i].num);
            end else begin
                issue_start(vecs[i].base, vecs[i].num);
                feed_burst(vecs[i].base, vecs[i].num, vecs[i].vmode, (i == 0), 1'b0, 0, 0, la);
                chk("last_addr", la, vecs[i].exp_last);
            end
            step();
        end

        // Back-to-back: start in the done cycle is accepted.
        issue_start(5, 2);
        feed_burst(5, 2, 0, 1'b0, 1'b1, 10, 1, la);
        chk("b2b_first_last", la, 6);
        chk("b2b_busy", busy_o, 1);
        chk("b2b_ready", in_ready_o, 1);
        chk("b2b_err", err_o, 0);
        feed_burst(10, 1, 0, 1'b0, 1'b0, 0, 0, la);
        chk("b2b_addr", la, 10);
        step();

        // Mid-burst reset after three beats of a two-word burst.
        issue_start(0, 2);
        in_valid_i = 1'b1;
        in_data_i  = 32'hAAAA0001;
        step();
        in_data_i = 32'hAAAA0002;
        step();
        chk("mr_wren", wren_o, 1);
        chk("mr_wrdata", wrdata_o, 64'hAAAA0002AAAA0001);
        chk("mr_wraddr", wraddr_o, 0);
        in_data_i = 32'hAAAA0003;
        step();
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        step();
        chk("mr_ready", in_ready_o, 0);
        chk("mr_wren0", wren_o, 0);
        chk("mr_wraddr0", wraddr_o, 0);
        chk("mr_wrdata0", wrdata_o, 0);
        chk("mr_busy", busy_o, 0);
        chk("mr_done", done_o, 0);
        chk("mr_err", err_o, 0);
        rst_i      = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 32'hAAAA0004;
        repeat (4) begin
            step();
            chk("mr_no_write", wren_o, 0);
            chk("mr_idle", busy_o, 0);
        end
        in_valid_i = 1'b0;
        step();
        issue_start(0, 2);
        feed_burst(0, 2, 0, 1'b1, 1'b0, 0, 0, la);
        chk("mr_basic_last", la, 1);
        chk("mr_basic_data", wrdata_o, 64'h4444444433333333);
        step();

        // Randomized bursts.
        for (int r = 0; r < 25; r++) begin
            rb = $urandom_range(0, 150);
            rn = $urandom_range(0, 6);
            if (rn == 0 || rb >= DEPTH) begin
                err_start(rb, rn);
            end else begin
                issue_start(rb, rn);
                feed_burst(rb, rn, 1, 1'b0, 1'b0, 0, 0, la);
                chk("rnd_last", la, (rb + rn - 1) % DEPTH);
            end
            repeat ($urandom_range(0, 2)) step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
